store_buffer_ctrl: RTL and testbench
====================================

STORE_BUFFER_CTRL -- requirements
Module: store_buffer_ctrl

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, meaning the number of committed-store entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port push_valid_i, input, 1: a committed store from WB (store_buffer_we qualified) is pushed this cycle.
REQ-005 SHALL have ports push_addr_i (input, 32), push_wdata_i (input, 32), push_wstrb_i (input, 4) and push_uncache_i (input, 1): the fields of the pushed store.
REQ-006 SHALL have ports full_o (output, 1) and empty_o (output, 1): buffer occupancy flags.
REQ-007 SHALL have ports ld_chk_valid_i (input, 1) and ld_chk_addr_i (input, 32): the MEM-stage load address to be hazard-checked.
REQ-008 SHALL have port ld_hit_o, output, 1: the load overlaps a buffered or in-flight store; MEM must stall.
REQ-009 SHALL have ports pipe_req_i (input, 1) and pipe_grant_o (output, 1): the pipeline asks for the dcache port and is granted it.
REQ-010 SHALL have ports sb_req_o (output, 1), sb_addr_o (output, 32), sb_wdata_o (output, 32), sb_wstrb_o (output, 4) and sb_uncache_o (output, 1): the drain request to the dcache.
REQ-011 SHALL have ports sb_addr_ok_i (input, 1) and sb_data_ok_i (input, 1): the dcache handshake responses.

Function
REQ-012 SHALL hold a circular FIFO with head/tail pointers of log2(SB_DEPTH) bits that wrap modulo SB_DEPTH, and a count of 0..SB_DEPTH.
REQ-013 SHALL write a push to the tail entry and advance tail; a push while full_o=1 SHALL be ignored and is a protocol error (assert in simulation).
REQ-014 SHALL drive full_o=(count==SB_DEPTH) and empty_o=(count==0), both registered-state derived and with no combinational path from push_valid_i.
REQ-015 SHALL implement drain FSM IDLE/REQ/WAIT:
- IDLE->REQ when not empty and drain allowed (REQ-016).
- REQ: sb_req_o=1 with head fields; ->WAIT on sb_addr_ok_i.
- WAIT: ->IDLE on sb_data_ok_i, which pops the head (count-1, head+1).
REQ-016 SHALL allow drain when pipe_req_i=0, OR full_o=1, OR the head entry is uncache; otherwise the pipeline has priority.
REQ-017 SHALL assert pipe_grant_o=1 only when the FSM is IDLE and drain is not starting this cycle; pipe_grant_o SHALL be 0 in REQ and WAIT.
REQ-018 SHALL, when push and pop occur in the same cycle, leave count unchanged and update both pointers; this includes the full case, where the pop occurs first within the cycle semantics.
REQ-019 SHALL keep sb_addr_o/wdata/wstrb/uncache stable from entry to REQ until the transition to IDLE.
REQ-020 SHALL drive ld_hit_o = ld_chk_valid_i AND (some valid entry, including the in-flight head, has addr[31:2]==ld_chk_addr_i[31:2] AND a nonzero wstrb); this is combinational, 0 cycles.
REQ-021 SHALL make a push to the same word as ld_chk_addr_i visible in ld_hit_o from the next cycle.
REQ-022 SHALL never reorder or drop entries; each entry is drained exactly once in push order.
REQ-023 SHALL not support a flush: entries are committed stores and survive excep_flush.

Reset
REQ-024 SHALL, while rst_n=0: head=tail=0, count=0, FSM=IDLE, sb_req_o=0, pipe_grant_o=0, ld_hit_o=0, full_o=0, empty_o=1.
REQ-025 SHALL drop any in-flight dcache transaction on reset mid-WAIT; sb_data_ok_i after reset SHALL be ignored in IDLE.
REQ-026 SHALL not reset entry payload registers; valid is tracked by count and pointers only.

Structure
REQ-027 SHALL take SB_DEPTH default and the FSM state encodings from the shared define.v (`SbIdle/`SbReq/`SbWait, `SbDepth).
REQ-028 SHALL be implemented as one sub-module: sb_fifo (storage, pointers, count, per-entry address compare vector); the FSM and arbitration live in the top level.

Verification
REQ-029 SHALL cover: push 4 stores with pipe_req_i=0 and addr_ok/data_ok one cycle each -> drained in order, with sb_addr_o sequence matching the push sequence, then empty_o=1.
REQ-030 SHALL cover: pipe_req_i=1 held, push 3 cached stores -> no sb_req_o, pipe_grant_o=1; 4th push -> full_o=1, then sb_req_o next cycle and pipe_grant_o=0.
REQ-031 SHALL cover: buffer holds 0x1000_0004 wstrb 4'b0011, load check 0x1000_0006 -> ld_hit_o=1; load check 0x1000_0008 -> 0.
REQ-032 SHALL cover: full buffer with push and data_ok pop in the same cycle -> count stays 4, tail wraps to head+0, no entry lost.
REQ-033 SHALL cover: rst_n low during WAIT -> outputs at reset values asynchronously; a late sb_data_ok_i does not change count.
REQ-034 SHALL cover: head uncache with pipe_req_i=1 -> drain starts immediately and pipe_grant_o=0.

Source files
------------

// File: rtl/store_buffer_ctrl_pkg.sv
// rtl/store_buffer_ctrl_pkg.sv - shared depth, drain FSM encodings and entry type for the store buffer
package store_buffer_ctrl_pkg;

  localparam int SB_DEPTH_DEF = 4;

  localparam logic [1:0] SB_IDLE = 2'd0;
  localparam logic [1:0] SB_REQ  = 2'd1;
  localparam logic [1:0] SB_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        uncache;
  } sb_entry_t;

  // Word-granular overlap: the byte offset bits never separate two accesses.
  function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
    return ((a ^ b) & 32'hffff_fffc) == 32'h0;
  endfunction

endpackage

// File: rtl/store_buffer_ctrl_sb_fifo.sv
// rtl/store_buffer_ctrl_sb_fifo.sv - committed-store circular FIFO with per-entry load overlap vector
module sb_fifo
  import store_buffer_ctrl_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [31:0]       push_addr,
  input  logic [31:0]       push_wdata,
  input  logic [3:0]        push_wstrb,
  input  logic              push_uncache,
  input  logic              pop,
  input  logic [31:0]       chk_addr,
  output logic [31:0]       head_addr,
  output logic [31:0]       head_wdata,
  output logic [3:0]        head_wstrb,
  output logic              head_uncache,
  output logic              full,
  output logic              empty,
  output logic [DEPTH-1:0]  hit_vec
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t         entries [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              push_acc;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full buffer still accepts a push in the cycle its head retires.
  assign push_acc = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_acc) tail <= tail + PW'(1);
      if (pop)      head <= head + PW'(1);
      if (push_acc && !pop)      count <= count + CW'(1);
      else if (pop && !push_acc) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) entries[tail] <= {push_addr, push_wdata, push_wstrb, push_uncache};
  end

  assign head_addr    = entries[head].addr;
  assign head_wdata   = entries[head].wdata;
  assign head_wstrb   = entries[head].wstrb;
  assign head_uncache = entries[head].uncache;

  // Entry g is live when its distance from head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
    logic [PW-1:0] off;
    assign off        = PW'(g) - head;
    assign hit_vec[g] = ({1'b0, off} < count) && same_word(entries[g].addr, chk_addr)
                        && (entries[g].wstrb != 4'b0000);
  end

  push_when_full : assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/store_buffer_ctrl.sv
// rtl/store_buffer_ctrl.sv - store buffer drain FSM and dcache port arbitration against the pipeline
module store_buffer_ctrl
  import store_buffer_ctrl_pkg::*;
#(
  parameter int SB_DEPTH = SB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_valid_i,
  input  logic [31:0] push_addr_i,
  input  logic [31:0] push_wdata_i,
  input  logic [3:0]  push_wstrb_i,
  input  logic        push_uncache_i,
  output logic        full_o,
  output logic        empty_o,
  input  logic        ld_chk_valid_i,
  input  logic [31:0] ld_chk_addr_i,
  output logic        ld_hit_o,
  input  logic        pipe_req_i,
  output logic        pipe_grant_o,
  output logic        sb_req_o,
  output logic [31:0] sb_addr_o,
  output logic [31:0] sb_wdata_o,
  output logic [3:0]  sb_wstrb_o,
  output logic        sb_uncache_o,
  input  logic        sb_addr_ok_i,
  input  logic        sb_data_ok_i
);

  logic [1:0]          state;
  logic                full;
  logic                empty;
  logic                pop;
  logic                head_uncache;
  logic                drain_ok;
  logic                drain_start;
  logic [SB_DEPTH-1:0] hit_vec;

  assign pop = (state == SB_WAIT) && sb_data_ok_i;

  sb_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push         (push_valid_i),
    .push_addr    (push_addr_i),
    .push_wdata   (push_wdata_i),
    .push_wstrb   (push_wstrb_i),
    .push_uncache (push_uncache_i),
    .pop          (pop),
    .chk_addr     (ld_chk_addr_i),
    .head_addr    (sb_addr_o),
    .head_wdata   (sb_wdata_o),
    .head_wstrb   (sb_wstrb_o),
    .head_uncache (head_uncache),
    .full         (full),
    .empty        (empty),
    .hit_vec      (hit_vec)
  );

  // Pipeline wins the port unless the buffer is full or an uncached store blocks the head.
  assign drain_ok    = !pipe_req_i || full || head_uncache;
  assign drain_start = (state == SB_IDLE) && !empty && drain_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SB_IDLE;
    end else begin
      case (state)
        SB_IDLE: if (drain_start)  state <= SB_REQ;
        SB_REQ:  if (sb_addr_ok_i) state <= SB_WAIT;
        SB_WAIT: if (sb_data_ok_i) state <= SB_IDLE;
        default:                   state <= SB_IDLE;
      endcase
    end
  end

  assign sb_req_o     = (state == SB_REQ);
  assign sb_uncache_o = head_uncache;
  assign pipe_grant_o = rst_n && pipe_req_i && (state == SB_IDLE) && !drain_start;
  assign ld_hit_o     = ld_chk_valid_i && (|hit_vec);
  assign full_o       = full;
  assign empty_o      = empty;

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// tb/tb_store_buffer_ctrl.sv - randomized scoreboard bench for store_buffer_ctrl
module tb_store_buffer_ctrl;

  localparam int D = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        unc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push_valid_i = 1'b0;
  logic [31:0] push_addr_i = '0;
  logic [31:0] push_wdata_i = '0;
  logic [3:0]  push_wstrb_i = '0;
  logic        push_uncache_i = 1'b0;
  logic        full_o, empty_o, ld_hit_o, pipe_grant_o;
  logic        ld_chk_valid_i = 1'b0;
  logic [31:0] ld_chk_addr_i = '0;
  logic        pipe_req_i = 1'b0;
  logic        sb_req_o, sb_uncache_o;
  logic [31:0] sb_addr_o, sb_wdata_o;
  logic [3:0]  sb_wstrb_o;
  logic        sb_addr_ok_i = 1'b0;
  logic        sb_data_ok_i = 1'b0;

  always #5 clk = ~clk;

  store_buffer_ctrl #(.SB_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid_i(push_valid_i), .push_addr_i(push_addr_i), .push_wdata_i(push_wdata_i),
    .push_wstrb_i(push_wstrb_i), .push_uncache_i(push_uncache_i),
    .full_o(full_o), .empty_o(empty_o),
    .ld_chk_valid_i(ld_chk_valid_i), .ld_chk_addr_i(ld_chk_addr_i), .ld_hit_o(ld_hit_o),
    .pipe_req_i(pipe_req_i), .pipe_grant_o(pipe_grant_o),
    .sb_req_o(sb_req_o), .sb_addr_o(sb_addr_o), .sb_wdata_o(sb_wdata_o),
    .sb_wstrb_o(sb_wstrb_o), .sb_uncache_o(sb_uncache_o),
    .sb_addr_ok_i(sb_addr_ok_i), .sb_data_ok_i(sb_data_ok_i)
  );

  // Reference model: buffer contents in push order, plus where the head drain stands.
  ent_t mq[$];
  ent_t exp_q[$];
  bit   mreq = 0;
  bit   mwait = 0;
  bit   done = 0;
  bit   timed_out = 0;
  int   resp_mode = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_resp();
    case (resp_mode)
      0: begin sb_addr_ok_i = mreq; sb_data_ok_i = mwait; end
      1: begin
        sb_addr_ok_i = mreq && ($urandom_range(0, 2) != 0);
        sb_data_ok_i = mwait && ($urandom_range(0, 3) != 0);
      end
      2: begin sb_addr_ok_i = mreq; sb_data_ok_i = 1'b0; end
      default: begin sb_addr_ok_i = 1'b0; sb_data_ok_i = 1'b1; end
    endcase
  endtask

  task automatic tick();
    bit   pop_now, acc, start;
    ent_t cur;
    @(posedge clk);
    if (rst_n) begin
      cur     = {push_addr_i, push_wdata_i, push_wstrb_i, push_uncache_i};
      pop_now = mwait && sb_data_ok_i;
      acc     = push_valid_i && (mq.size() < D || pop_now);
      start   = !mreq && !mwait && mq.size() > 0 &&
                (!pipe_req_i || mq.size() == D || mq[0].unc);
      if (pop_now) begin mq.delete(0); mwait = 0; end
      else if (mreq && sb_addr_ok_i) begin mreq = 0; mwait = 1; end
      else if (start) mreq = 1;
      if (acc) begin mq.push_back(cur); exp_q.push_back(cur); end
    end
    #1;
  endtask

  task automatic cyc(bit push, logic [31:0] a, logic [3:0] ws, bit unc, bit preq, bit cv,
                     logic [31:0] ca);
    push_valid_i   = push;
    push_addr_i    = a;
    push_wdata_i   = $urandom;
    push_wstrb_i   = ws;
    push_uncache_i = unc;
    pipe_req_i     = preq;
    ld_chk_valid_i = cv;
    ld_chk_addr_i  = ca;
    drive_resp();
    tick();
  endtask

  task automatic drain_all();
    int n = 0;
    while ((mq.size() > 0 || mreq || mwait) && n < 200) begin
      cyc(0, '0, '0, 0, 0, 0, '0);
      n++;
    end
    if (n >= 200) timed_out = 1;
  endtask

  task automatic wait_for_wait(bit preq);
    int n = 0;
    while (!mwait && n < 20) begin
      cyc(0, '0, '0, 0, preq, 0, '0);
      n++;
    end
    if (!mwait) timed_out = 1;
  endtask

  initial begin : stimulus
    bit pop_plan;
    for (int i = 0; i < 3; i++) cyc(0, '0, '0, 0, 1, 1, 32'h0000_0000);
    rst_n = 1'b1;

    // In-order drain with an idle pipeline and single-cycle dcache handshakes.
    resp_mode = 0;
    for (int i = 0; i < 4; i++) cyc(1, 32'h0800_0000 + 32'(i * 4), 4'hf, 0, 0, 0, '0);
    drain_all();

    // Pipeline priority until the buffer fills.
    for (int i = 0; i < 4; i++) cyc(1, 32'h0900_0000 + 32'(i * 16), 4'hf, 0, 1, 0, '0);
    for (int i = 0; i < 6; i++) cyc(0, '0, '0, 0, 1, 0, '0);
    drain_all();

    // Load hazard compare, including push visibility one cycle later and zero strobes.
    cyc(1, 32'h1000_0004, 4'b0011, 0, 1, 1, 32'h1000_0006);
    cyc(0, '0, '0, 0, 1, 1, 32'h1000_0006);
    cyc(0, '0, '0, 0, 1, 1, 32'h1000_0008);
    cyc(0, '0, '0, 0, 1, 0, 32'h1000_0006);
    cyc(1, 32'h2000_0000, 4'b0000, 0, 1, 0, '0);
    cyc(0, '0, '0, 0, 1, 1, 32'h2000_0000);
    drain_all();

    // Push and pop in the same cycle while full.
    resp_mode = 2;
    for (int i = 0; i < 4; i++) cyc(1, 32'h3000_0000 + 32'(i * 4), 4'hf, 0, 1, 0, '0);
    wait_for_wait(1);
    resp_mode = 0;
    cyc(1, 32'h3000_0010, 4'hf, 0, 1, 1, 32'h3000_0010);
    resp_mode = 2;
    cyc(0, '0, '0, 0, 1, 1, 32'h3000_0010);
    cyc(0, '0, '0, 0, 1, 1, 32'h3000_0000);
    resp_mode = 0;
    drain_all();

    // Uncached head drains immediately despite a pipeline request.
    cyc(1, 32'h5000_0000, 4'hf, 1, 1, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, '0, '0, 0, 1, 0, '0);
    drain_all();

    // Asynchronous reset while waiting on data_ok, then a stray data_ok.
    resp_mode = 2;
    cyc(1, 32'h4000_0000, 4'hf, 0, 0, 0, '0);
    cyc(1, 32'h4000_0004, 4'hf, 0, 0, 0, '0);
    wait_for_wait(0);
    rst_n = 1'b0;
    mq.delete();
    exp_q.delete();
    mreq = 0;
    mwait = 0;
    cyc(0, '0, '0, 0, 1, 1, 32'h4000_0004);
    cyc(0, '0, '0, 0, 1, 1, 32'h4000_0004);
    rst_n = 1'b1;
    resp_mode = 3;
    cyc(0, '0, '0, 0, 0, 0, '0);
    cyc(0, '0, '0, 0, 1, 0, '0);
    resp_mode = 0;
    cyc(0, '0, '0, 0, 1, 0, '0);

    // Randomized traffic against the model.
    resp_mode = 1;
    for (int i = 0; i < 800; i++) begin
      drive_resp();
      pop_plan       = mwait && sb_data_ok_i;
      push_valid_i   = ($urandom_range(0, 1) == 1) && (mq.size() < D || pop_plan);
      push_addr_i    = 32'h1000_0000 | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
      push_wdata_i   = $urandom;
      push_wstrb_i   = 4'($urandom_range(0, 15));
      push_uncache_i = ($urandom_range(0, 5) == 0);
      pipe_req_i     = ($urandom_range(0, 3) != 0);
      ld_chk_valid_i = $urandom_range(0, 1) == 1;
      ld_chk_addr_i  = 32'h1000_0000 | 32'($urandom_range(0, 9) << 2) | 32'($urandom_range(0, 3));
      tick();
    end
    resp_mode = 0;
    drain_all();
    cyc(0, '0, '0, 0, 0, 0, '0);
    done = 1;
  end

  initial begin : monitor
    ent_t cap = '0;
    bit   prev_req = 0;
    bit   exp_hit, exp_grant;
    forever begin
      @(negedge clk);
      if (done) break;
      exp_hit = 0;
      if (ld_chk_valid_i)
        foreach (mq[k])
          if (mq[k].addr[31:2] == ld_chk_addr_i[31:2] && mq[k].wstrb != 4'b0) exp_hit = 1;
      exp_grant = rst_n && pipe_req_i && !mreq && !mwait &&
                  !(mq.size() > 0 && (mq.size() == D || mq[0].unc));
      chk("full_o", 72'(full_o), 72'(mq.size() == D));
      chk("empty_o", 72'(empty_o), 72'(mq.size() == 0));
      chk("sb_req_o", 72'(sb_req_o), 72'(mreq));
      chk("ld_hit_o", 72'(ld_hit_o), 72'(exp_hit));
      chk("pipe_grant_o", 72'(pipe_grant_o), 72'(exp_grant));
      if (sb_req_o && !prev_req && exp_q.size() > 0) begin
        cap = exp_q.pop_front();
        chk("drain_order", 72'({sb_addr_o, sb_wdata_o, sb_wstrb_o, sb_uncache_o}), 72'(cap));
      end else if (sb_req_o || mwait) begin
        chk("drain_stable", 72'({sb_addr_o, sb_wdata_o, sb_wstrb_o, sb_uncache_o}), 72'(cap));
      end
      prev_req = sb_req_o;
    end
    chk("undrained_entries", 72'(exp_q.size()), 72'(0));
    chk("wait_bound", 72'(timed_out), 72'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no completion expected completion by %0t", $time);
    $fatal(1, "bench did not complete");
  end

endmodule
